alu_74181_seq_ctrl: RTL

//  Sequencer that runs WIDTH-bit operations on one 4-bit 74181 slice, one nibble per cycle, LSB first.

---
 rtl/alu_74181_pkg.sv | 16 +
 rtl/ALU_74181_comb.sv | 27 ++
 rtl/alu_74181_seq_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_74181_pkg.sv
// Shared types and 74181 function-select codes
// for the nibble-serial ALU sequencer.
package alu_74181_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] ALU_S_ADD = 4'b1001;
  localparam logic [3:0] ALU_S_SUB = 4'b0110;
  // Same code as SUB; selects A xor B when M=1
  localparam logic [3:0] ALU_S_XOR = 4'b0110;

endpackage

// File: rtl/ALU_74181_comb.sv
// One 4-bit 74181 slice, active-high data, active-low carry.
// F = X + Y + carry in arithmetic mode, ~(X ^ Y) in logic mode.
module ALU_74181_comb (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn_out,
  output logic       a_eq_b
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;

  always_comb begin
    x      = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y      = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
    sum    = {1'b0, x} + {1'b0, y} + {4'b0000, ~cn};
    f      = m ? ~(x ^ y) : sum[3:0];
    cn_out = ~sum[4];
    a_eq_b = &f;
  end

endmodule

// File: rtl/alu_74181_seq_ctrl.sv
// WIDTH-bit ALU run one nibble per cycle on a single 74181 slice.
// Define ALU_SEQ_OVF_EN to compute signed overflow on rsp_ovf.
module alu_74181_seq_ctrl
  import alu_74181_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_s,
  input  logic             req_m,
  input  logic             req_cin_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout_n,
  output logic             rsp_eq,
  output logic             rsp_zero,
  output logic             rsp_ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t state_q, state_d;

  logic [CW-1:0]    nib_cnt;
  logic [WIDTH-1:0] a_q, b_q, f_q, f_next;
  logic [3:0]       s_q;
  logic             m_q, carry_q;
  logic             eq_acc, eq_q, zero_q;
  logic             accept, run, last;

  logic [3:0] a_nib, b_nib, f_nib;
  logic       cn_out, a_eq_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = RUN;
      RUN:  if (last)      state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    run       = (state_q == RUN);
  end

  assign accept = req_valid && req_ready;
  assign last   = (nib_cnt == CW'(NIB - 1));

  // Constant-index mux keeps the nibble select lint-clean
  always_comb begin
    a_nib  = 4'h0;
    b_nib  = 4'h0;
    f_next = f_q;
    for (int k = 0; k < NIB; k++) begin
      if (nib_cnt == CW'(k)) begin
        a_nib            = a_q[4*k +: 4];
        b_nib            = b_q[4*k +: 4];
        f_next[4*k +: 4] = f_nib;
      end
    end
  end

  ALU_74181_comb u_slice (
    .a      (a_nib),
    .b      (b_nib),
    .s      (s_q),
    .m      (m_q),
    .cn     (carry_q),
    .f      (f_nib),
    .cn_out (cn_out),
    .a_eq_b (a_eq_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      s_q     <= 4'h0;
      m_q     <= 1'b0;
      carry_q <= 1'b1;
      eq_acc  <= 1'b0;
      eq_q    <= 1'b0;
      zero_q  <= 1'b0;
      nib_cnt <= '0;
    end else if (accept) begin
      a_q     <= req_a;
      b_q     <= req_b;
      s_q     <= req_s;
      m_q     <= req_m;
      carry_q <= req_cin_n;
      eq_acc  <= 1'b1;
      nib_cnt <= '0;
    end else if (run) begin
      f_q     <= f_next;
      carry_q <= cn_out;
      eq_acc  <= eq_acc & a_eq_b;
      if (last) begin
        eq_q   <= eq_acc & a_eq_b;
        zero_q <= (f_next == '0);
      end else begin
        nib_cnt <= nib_cnt + CW'(1);
      end
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = 1'b0;
    if (!m_q && s_q == ALU_S_ADD)
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
              (f_nib[3] != a_q[WIDTH-1]);
    else if (!m_q && s_q == ALU_S_SUB)
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
              (f_nib[3] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ovf_q <= 1'b0;
    else if (run && last) ovf_q <= ovf_d;
  end

  assign rsp_ovf = ovf_q;
`else
  assign rsp_ovf = 1'b0;
`endif

  assign rsp_f      = f_q;
  assign rsp_cout_n = carry_q;
  assign rsp_eq     = eq_q;
  assign rsp_zero   = zero_q;

endmodule
